pixel_writer: RTL and testbench

- Downstream stage of search: consumes each selected result (found, sel_address_syn, sel_data_syn) and writes it to pixel memory over a simple req/ack write port.
- Buffers results in a small FIFO so search is never stalled by memory latency unless the FIFO is full.
- Counts pixels written and pulses frame_done once per complete frame.

---
 rtl/pixel_writer.sv | 115 +++++++++++
 tb/tb_pixel_writer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - buffers search results in a FIFO and writes them to pixel memory
module pixel_writer #(
    parameter int DEPTH      = 4,
    parameter int NUM_PIXELS = 307200
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        found,
    input  logic [31:0] sel_address_syn,
    input  logic [7:0]  sel_data_syn,
    output logic        accept,
    output logic        full,
    output logic        empty,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ack,
    output logic        frame_done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t        state, state_next;
    logic [39:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [31:0]   pix_cnt;
    logic          push, pop, load;

    // A pop in the same cycle never frees a slot: full comes from the registered count.
    assign accept = found && !full;
    assign push   = accept;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    load       = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (wr_ack) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {sel_address_syn, sel_data_syn};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            pix_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            // The head entry stays in the FIFO until the memory acknowledges it.
            if (load) begin
                wr_en   <= 1'b1;
                wr_addr <= mem[rd_ptr][39:8];
                wr_data <= mem[rd_ptr][7:0];
            end else if (pop) begin
                wr_en  <= 1'b0;
                rd_ptr <= rd_ptr + PW'(1);
            end
            frame_done <= 1'b0;
            if (pop) begin
                if (pix_cnt == 32'(NUM_PIXELS - 1)) begin
                    pix_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// tb/tb_pixel_writer.sv - scoreboard bench for pixel_writer
module tb_pixel_writer;

    localparam int NP = 5;

    logic        clk;
    logic        n_rst;
    logic        found;
    logic [31:0] sel_address_syn;
    logic [7:0]  sel_data_syn;
    logic        accept;
    logic        full;
    logic        empty;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    logic [39:0] sb_q[$];
    int ack_cnt = 0;
    logic exp_fd = 1'b0;
    int fd_seen = 0;

    pixel_writer #(.DEPTH(4), .NUM_PIXELS(NP)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .found           (found),
        .sel_address_syn (sel_address_syn),
        .sel_data_syn    (sel_data_syn),
        .accept          (accept),
        .full            (full),
        .empty           (empty),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_ack          (wr_ack),
        .frame_done      (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every acknowledged write and tracks frame pulses.
    always @(negedge clk) begin
        if (!n_rst) begin
            ack_cnt = 0;
            exp_fd  = 1'b0;
        end else begin
            chk("frame_done", {39'd0, frame_done}, {39'd0, exp_fd});
            if (frame_done) fd_seen++;
            exp_fd = 1'b0;
            if (wr_en && wr_ack) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h expected none", {wr_addr, wr_data});
                end else begin
                    chk("write", {wr_addr, wr_data}, sb_q.pop_front());
                end
                ack_cnt++;
                if (ack_cnt == NP) begin
                    ack_cnt = 0;
                    exp_fd  = 1'b1;
                end
            end
        end
    end

    task automatic drive_px(input logic [31:0] a, input logic [7:0] d, input logic exp_acc);
        @(posedge clk); #1;
        found = 1'b1;
        sel_address_syn = a;
        sel_data_syn = d;
        #1;
        chk("accept", {39'd0, accept}, {39'd0, exp_acc});
        if (exp_acc) sb_q.push_back({a, d});
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        found = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !empty || wr_en) && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        chk({name, "_drained"}, {39'd0, (sb_q.size() == 0 && empty && !wr_en)}, 40'd1);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        n_rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0;
        found = 1'b0;
        sel_address_syn = '0;
        sel_data_syn = '0;
        wr_ack = 1'b0;
        #12;
        chk("rst_empty", {39'd0, empty}, 40'd1);
        chk("rst_full", {39'd0, full}, 40'd0);
        chk("rst_wr_en", {39'd0, wr_en}, 40'd0);
        chk("rst_wr_addr", {8'd0, wr_addr}, 40'd0);
        chk("rst_frame_done", {39'd0, frame_done}, 40'd0);
        @(negedge clk);
        @(posedge clk); #1;
        n_rst = 1'b1;

        // Single pixel with immediate ack
        wr_ack = 1'b1;
        drive_px(32'h10, 8'hA5, 1'b1);
        idle_cycle();
        chk("t1_wr_en_p1", {39'd0, wr_en}, 40'd0);
        @(posedge clk); #1;
        chk("t1_wr_en_p2", {39'd0, wr_en}, 40'd1);
        chk("t1_wr_word", {wr_addr, wr_data}, {32'h10, 8'hA5});
        @(posedge clk); #1;
        chk("t1_wr_en_p3", {39'd0, wr_en}, 40'd0);
        chk("t1_empty", {39'd0, empty}, 40'd1);

        // Fill to full with ack held low, then stall-hold
        wr_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_px(32'(i), 8'(8'h30 + i), (i < 4));
        end
        idle_cycle();
        chk("t2_full", {39'd0, full}, 40'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_wr_en", {39'd0, wr_en}, 40'd1);
            chk("stall_word", {wr_addr, wr_data}, {32'h0, 8'h30});
            chk("stall_full", {39'd0, full}, 40'd1);
        end
        wr_ack = 1'b1;
        drain("t2");

        // Pointer wrap: ten pixels, every other cycle
        for (int i = 0; i < 10; i++) begin
            drive_px(32'h100 + 32'(i), 8'(i), 1'b1);
            chk("wrap_full", {39'd0, full}, 40'd0);
            idle_cycle();
            chk("wrap_full", {39'd0, full}, 40'd0);
        end
        drain("wrap");

        // Frame: 12 writes with NUM_PIXELS = 5 gives two pulses
        do_reset();
        fd_seen = 0;
        for (int i = 0; i < 12; i++) begin
            drive_px(32'h200 + 32'(i), 8'(8'h50 + i), 1'b1);
            idle_cycle();
        end
        drain("frame");
        repeat (3) @(posedge clk);
        #2;
        chk("frame_pulses", 40'(fd_seen), 40'd2);

        // Async reset mid-write with three entries buffered
        wr_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_px(32'h300 + 32'(i), 8'(8'h70 + i), 1'b1);
        end
        idle_cycle();
        @(posedge clk); #1;
        chk("ar_wr_en_before", {39'd0, wr_en}, 40'd1);
        @(negedge clk); #2;
        n_rst = 1'b0;
        #1;
        chk("ar_wr_en", {39'd0, wr_en}, 40'd0);
        chk("ar_empty", {39'd0, empty}, 40'd1);
        chk("ar_full", {39'd0, full}, 40'd0);
        sb_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        n_rst = 1'b1;
        wr_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("ar_no_write", {39'd0, wr_en}, 40'd0);
        end
        drive_px(32'h400, 8'hEE, 1'b1);
        idle_cycle();
        drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
